tdc_meas_sequencer: RTL and testbench
=====================================

# tdc_meas_sequencer

Sequences one time-interval measurement per second between the local top-of-second (TOS) and the raw GPS PPS edge. Each second it arms on the synchronized raw PPS rising edge and fires the TDC stop on the next slow-clock rising edge. It then reads the TDC fine result through a request/acknowledge port and hands a coarse+fine record to the uC over a valid/ready interface. It sits between the TOS/slow-clock generator, the external TDC and the uC.

## Interface
- ClocksPerSecond, 19200000: clk_tf cycles per second.
- StopWidth, 960: cycles tdc_stop stays high. Must be less than the slow-clock period.
- ReadTimeout, 256: cycles to wait for tdc_rd_ack before giving up.
- FineWidth, 24: width of the TDC result.

- clk_tf  in  1  timing clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- tos_mark  in  1  one-cycle pulse; the next clk_tf edge is the top of second.
- pps_raw_rise  in  1  one-cycle pulse; synchronized raw PPS rising edge.
- slow_clock_rise_next  in  1  the next clk_tf edge is a slow-clock rising edge.
- tdc_stop  out  1  registered TDC stop pulse.
- tdc_rd_req  out  1  request to read the TDC result.
- tdc_rd_ack  in  1  one-cycle acknowledge; tdc_rd_data is valid in the same cycle.
- tdc_rd_data  in  FineWidth  TDC fine result.
- meas_valid  out  1  a measurement record is available.
- meas_ready  in  1  the uC accepts the record.
- meas_coarse  out  $clog2(ClocksPerSecond)  clk_tf edges from the TOS edge to the tdc_stop rising edge.
- meas_fine  out  FineWidth  latched TDC result.
- meas_status  out  2  0 = OK, 1 = PPS missing, 2 = read timeout.
- meas_skipped  out  1  at least one second was skipped since the previous accepted record.
- busy  out  1  the state machine is not in S_idle.

## Operation
- States and transitions:
  - S_idle: on tos_mark, go to S_wait_pps.
  - S_wait_pps: on pps_raw_rise, go to S_arm. On tos_mark, status = MISSING, go to S_present.
  - S_arm: on slow_clock_rise_next, go to S_stop.
  - S_stop: after StopWidth cycles, go to S_read.
  - S_read: on tdc_rd_ack, go to S_present. On timeout, status = TIMEOUT, go to S_present.
  - S_present: on meas_valid && meas_ready, go to S_idle.
- Coarse counter:
  - Loads 0 on the edge that ends a tos_mark cycle.
  - Increments by 1 on every later edge.
  - Saturates at ClocksPerSecond-1.
- meas_coarse latches the counter value on the edge where tdc_stop rises.
- tdc_stop goes high on the edge ending the S_arm cycle in which slow_clock_rise_next is seen, and stays high for exactly StopWidth cycles.
- tdc_rd_req:
  - Held high throughout S_read; drops on the edge after ack.
  - meas_fine latches tdc_rd_data on the ack cycle.
  - If no ack arrives within ReadTimeout cycles of entering S_read: meas_fine = 0, status = TIMEOUT.
- MISSING record: meas_coarse = ClocksPerSecond-1 and meas_fine = 0.
- Record outputs are stable while meas_valid is high. meas_valid deasserts on the edge after acceptance.
- Skipped seconds: tos_mark seen in S_arm, S_stop, S_read or S_present (or the tos_mark that ends S_wait_pps) sets the sticky skip flag.
  - The flag is copied to meas_skipped when the next record is loaded into S_present.
  - The flag clears when that record is accepted.
  - Such a tos_mark never aborts an in-flight measurement.
- pps_raw_rise is ignored outside S_wait_pps, including in the same cycle as the tos_mark that leaves S_idle.
- Simultaneous tos_mark and pps_raw_rise in S_wait_pps: tos_mark wins (MISSING).
- Reset at any point forces S_idle. All outputs read 0: tdc_stop, tdc_rd_req, meas_valid, meas_coarse, meas_fine, meas_status, meas_skipped, busy. The skip flag and counter also clear.

## Timing
- TOS to counter: tos_mark in cycle t gives counter = 0 in cycle t+1.
- Arm latency: pps_raw_rise in cycle p (in S_wait_pps) puts the FSM in S_arm at cycle p+1.
- Stop rise: slow_clock_rise_next in cycle s (in S_arm) puts tdc_stop high from cycle s+1 through s+StopWidth. It is low at s+StopWidth+1.
- Read request: tdc_rd_req rises at s+StopWidth+1.
- Record presentation: ack in cycle a gives meas_valid high from cycle a+1. On timeout, meas_valid rises ReadTimeout+1 cycles after tdc_rd_req rose.
- Handshake: meas_valid and meas_ready both high in cycle v means the FSM is in S_idle at v+1. A tos_mark in cycle v+1 starts a new measurement.

## Test plan
- Nominal second:
  - Stimulus: tos_mark at cycle 0, pps_raw_rise at cycle 1000, slow_clock_rise_next at cycle 1919, ack at cycle 2900 with data 0x00ABCD.
  - Required: tdc_stop high for cycles 1920–2879; record coarse = 1919, fine = 0x00ABCD, status = 0, skipped = 0.
- PPS missing:
  - Stimulus: two tos_marks ClocksPerSecond apart with no PPS in between.
  - Required: record coarse = ClocksPerSecond-1, fine = 0, status = 1, skipped = 1.
- Read timeout:
  - Stimulus: never assert tdc_rd_ack.
  - Required: meas_valid rises ReadTimeout+1 cycles after tdc_rd_req; status = 2, fine = 0.
- Backpressure:
  - Stimulus: hold meas_ready low across two tos_marks, then accept; run a nominal next second.
  - Required: the first record stays stable throughout; the next record has skipped = 1.
- Simultaneous events:
  - Stimulus: pps_raw_rise in the same cycle as the tos_mark that leaves S_idle, then none.
  - Required: the PPS is ignored, and the next tos_mark yields status = 1.
- Reset mid-operation:
  - Stimulus: assert rst while tdc_stop is high.
  - Required: next cycle all outputs are 0, busy = 0; a subsequent nominal second measures correctly.

Source files
------------

// File: rtl/tdc_meas_sequencer.sv
// Once-per-second TOS-to-PPS interval measurement: arms on PPS, fires the TDC stop on the next
// slow-clock edge, reads the fine result and presents a coarse+fine record to the uC.
module tdc_meas_sequencer #(
    parameter int unsigned ClocksPerSecond = 19200000,
    parameter int unsigned StopWidth       = 960,
    parameter int unsigned ReadTimeout     = 256,
    parameter int unsigned FineWidth       = 24,
    localparam int unsigned CoarseWidth    = $clog2(ClocksPerSecond)
) (
    input  logic                   clk_tf,
    input  logic                   rst,
    input  logic                   tos_mark,
    input  logic                   pps_raw_rise,
    input  logic                   slow_clock_rise_next,
    output logic                   tdc_stop,
    output logic                   tdc_rd_req,
    input  logic                   tdc_rd_ack,
    input  logic [FineWidth-1:0]   tdc_rd_data,
    output logic                   meas_valid,
    input  logic                   meas_ready,
    output logic [CoarseWidth-1:0] meas_coarse,
    output logic [FineWidth-1:0]   meas_fine,
    output logic [1:0]             meas_status,
    output logic                   meas_skipped,
    output logic                   busy
);

    localparam int unsigned CntMax   = (StopWidth > ReadTimeout) ? StopWidth : ReadTimeout;
    localparam int unsigned CntWidth = $clog2(CntMax + 1);

    localparam logic [CoarseWidth-1:0] CoarseMax = CoarseWidth'(ClocksPerSecond - 1);
    localparam logic [CntWidth-1:0]    StopLast  = CntWidth'(StopWidth - 1);
    // Read phase lasts ReadTimeout+1 cycles so the timeout record lands ReadTimeout+1 after req.
    localparam logic [CntWidth-1:0]    ReadLast  = CntWidth'(ReadTimeout);

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusMissing = 2'd1;
    localparam logic [1:0] StatusTimeout = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitPps,
        StArm,
        StStop,
        StRead,
        StPresent
    } state_e;

    state_e                 state_q, state_d;
    logic [CoarseWidth-1:0] coarse_cnt_q, coarse_cnt_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   skip_q, skip_d;
    logic                   skip_set;
    logic                   load;
    logic                   tdc_stop_q, tdc_rd_req_q, meas_valid_q, busy_q;
    logic [CoarseWidth-1:0] meas_coarse_q, meas_coarse_d;
    logic [FineWidth-1:0]   meas_fine_q, meas_fine_d;
    logic [1:0]             meas_status_q, meas_status_d;
    logic                   meas_skipped_q, meas_skipped_d;

    always_comb begin
        coarse_cnt_d = coarse_cnt_q;
        if (tos_mark) begin
            coarse_cnt_d = '0;
        end else if (coarse_cnt_q != CoarseMax) begin
            coarse_cnt_d = coarse_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        skip_set       = 1'b0;
        load           = 1'b0;
        meas_coarse_d  = meas_coarse_q;
        meas_fine_d    = meas_fine_q;
        meas_status_d  = meas_status_q;
        meas_skipped_d = meas_skipped_q;
        skip_d         = skip_q;

        unique case (state_q)
            StIdle: begin
                if (tos_mark) begin
                    state_d = StWaitPps;
                end
            end
            StWaitPps: begin
                // A new second before any PPS closes this one as missing.
                if (tos_mark) begin
                    skip_set      = 1'b1;
                    load          = 1'b1;
                    meas_coarse_d = CoarseMax;
                    meas_fine_d   = '0;
                    meas_status_d = StatusMissing;
                    state_d       = StPresent;
                end else if (pps_raw_rise) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                skip_set = tos_mark;
                if (slow_clock_rise_next) begin
                    meas_coarse_d = coarse_cnt_d;
                    state_d       = StStop;
                end
            end
            StStop: begin
                skip_set = tos_mark;
                if (cnt_q == StopLast) begin
                    state_d = StRead;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRead: begin
                skip_set = tos_mark;
                if (tdc_rd_ack) begin
                    load          = 1'b1;
                    meas_fine_d   = tdc_rd_data;
                    meas_status_d = StatusOk;
                    state_d       = StPresent;
                end else if (cnt_q == ReadLast) begin
                    load          = 1'b1;
                    meas_fine_d   = '0;
                    meas_status_d = StatusTimeout;
                    state_d       = StPresent;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPresent: begin
                skip_set = tos_mark;
                if (meas_valid_q && meas_ready) begin
                    meas_skipped_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The flag moves into the record being loaded; later seconds accumulate for the next one.
        if (load) begin
            meas_skipped_d = skip_q | skip_set;
            skip_d         = 1'b0;
        end else begin
            skip_d = skip_q | skip_set;
        end
    end

    always_ff @(posedge clk_tf) begin
        if (rst) begin
            state_q        <= StIdle;
            coarse_cnt_q   <= '0;
            cnt_q          <= '0;
            skip_q         <= 1'b0;
            tdc_stop_q     <= 1'b0;
            tdc_rd_req_q   <= 1'b0;
            meas_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            meas_coarse_q  <= '0;
            meas_fine_q    <= '0;
            meas_status_q  <= '0;
            meas_skipped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            coarse_cnt_q   <= coarse_cnt_d;
            cnt_q          <= cnt_d;
            skip_q         <= skip_d;
            tdc_stop_q     <= (state_d == StStop);
            tdc_rd_req_q   <= (state_d == StRead);
            meas_valid_q   <= (state_d == StPresent);
            busy_q         <= (state_d != StIdle);
            meas_coarse_q  <= meas_coarse_d;
            meas_fine_q    <= meas_fine_d;
            meas_status_q  <= meas_status_d;
            meas_skipped_q <= meas_skipped_d;
        end
    end

    assign tdc_stop     = tdc_stop_q;
    assign tdc_rd_req   = tdc_rd_req_q;
    assign meas_valid   = meas_valid_q;
    assign busy         = busy_q;
    assign meas_coarse  = meas_coarse_q;
    assign meas_fine    = meas_fine_q;
    assign meas_status  = meas_status_q;
    assign meas_skipped = meas_skipped_q;

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed bench for tdc_meas_sequencer with a shortened second; cycle 0 is the tos_mark cycle.
module tb_tdc_meas_sequencer;

    localparam int unsigned Cps = 4000;
    localparam int unsigned Sw  = 960;
    localparam int unsigned Rt  = 256;
    localparam int unsigned Fw  = 24;
    localparam int unsigned Cw  = $clog2(Cps);

    logic          clk_tf = 1'b0;
    logic          rst;
    logic          tos_mark;
    logic          pps_raw_rise;
    logic          slow_clock_rise_next;
    logic          tdc_stop;
    logic          tdc_rd_req;
    logic          tdc_rd_ack;
    logic [Fw-1:0] tdc_rd_data;
    logic          meas_valid;
    logic          meas_ready;
    logic [Cw-1:0] meas_coarse;
    logic [Fw-1:0] meas_fine;
    logic [1:0]    meas_status;
    logic          meas_skipped;
    logic          busy;

    int n_asserts = 0;
    int n_fail    = 0;

    tdc_meas_sequencer #(
        .ClocksPerSecond(Cps),
        .StopWidth      (Sw),
        .ReadTimeout    (Rt),
        .FineWidth      (Fw)
    ) dut (
        .clk_tf              (clk_tf),
        .rst                 (rst),
        .tos_mark            (tos_mark),
        .pps_raw_rise        (pps_raw_rise),
        .slow_clock_rise_next(slow_clock_rise_next),
        .tdc_stop            (tdc_stop),
        .tdc_rd_req          (tdc_rd_req),
        .tdc_rd_ack          (tdc_rd_ack),
        .tdc_rd_data         (tdc_rd_data),
        .meas_valid          (meas_valid),
        .meas_ready          (meas_ready),
        .meas_coarse         (meas_coarse),
        .meas_fine           (meas_fine),
        .meas_status         (meas_status),
        .meas_skipped        (meas_skipped),
        .busy                (busy)
    );

    always #5 clk_tf = ~clk_tf;

    // Advance one cycle; sampling happens 1 time unit after the edge, pulses drop after one cycle.
    task automatic tick();
        @(posedge clk_tf);
        #1;
        tos_mark             = 1'b0;
        pps_raw_rise         = 1'b0;
        slow_clock_rise_next = 1'b0;
        tdc_rd_ack           = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".tdc_stop"}, 32'(tdc_stop), 0);
        chk({tag, ".tdc_rd_req"}, 32'(tdc_rd_req), 0);
        chk({tag, ".meas_valid"}, 32'(meas_valid), 0);
        chk({tag, ".meas_coarse"}, 32'(meas_coarse), 0);
        chk({tag, ".meas_fine"}, 32'(meas_fine), 0);
        chk({tag, ".meas_status"}, 32'(meas_status), 0);
        chk({tag, ".meas_skipped"}, 32'(meas_skipped), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic check_record(input string tag, input int unsigned coarse,
                                input int unsigned fine, input int unsigned status,
                                input int unsigned skipped);
        chk({tag, ".valid"}, 32'(meas_valid), 1);
        chk({tag, ".coarse"}, 32'(meas_coarse), coarse);
        chk({tag, ".fine"}, 32'(meas_fine), fine);
        chk({tag, ".status"}, 32'(meas_status), status);
        chk({tag, ".skipped"}, 32'(meas_skipped), skipped);
    endtask

    task automatic accept(input string tag);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        chk({tag, ".accept_valid"}, 32'(meas_valid), 0);
        chk({tag, ".accept_busy"}, 32'(busy), 0);
    endtask

    // tos at c0, pps at c1, slow at c2, stop c3..c2+Sw, ack on the first read cycle: coarse = 2.
    task automatic quick_second(input logic [Fw-1:0] data);
        tos_mark = 1'b1;
        tick();
        pps_raw_rise = 1'b1;
        tick();
        slow_clock_rise_next = 1'b1;
        tick();
        ticks(Sw);
        tdc_rd_ack  = 1'b1;
        tdc_rd_data = data;
        tick();
    endtask

    initial begin
        rst                  = 1'b1;
        tos_mark             = 1'b0;
        pps_raw_rise         = 1'b0;
        slow_clock_rise_next = 1'b0;
        tdc_rd_ack           = 1'b0;
        tdc_rd_data          = '0;
        meas_ready           = 1'b0;
        ticks(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Nominal second
        tos_mark = 1'b1;
        tick();                                   // cycle 1
        chk("nom.busy", 32'(busy), 1);
        ticks(999);                               // cycle 1000
        chk("nom.stop_idle", 32'(tdc_stop), 0);
        pps_raw_rise = 1'b1;
        tick();                                   // cycle 1001
        ticks(918);                               // cycle 1919
        slow_clock_rise_next = 1'b1;
        chk("nom.stop_pre", 32'(tdc_stop), 0);
        tick();                                   // cycle 1920
        chk("nom.stop_first", 32'(tdc_stop), 1);
        ticks(959);                               // cycle 2879
        chk("nom.stop_last", 32'(tdc_stop), 1);
        chk("nom.req_pre", 32'(tdc_rd_req), 0);
        tick();                                   // cycle 2880
        chk("nom.stop_low", 32'(tdc_stop), 0);
        chk("nom.req_rise", 32'(tdc_rd_req), 1);
        ticks(20);                                // cycle 2900
        tdc_rd_ack  = 1'b1;
        tdc_rd_data = 24'h00ABCD;
        chk("nom.valid_pre", 32'(meas_valid), 0);
        chk("nom.req_ack", 32'(tdc_rd_req), 1);
        tick();                                   // cycle 2901
        chk("nom.req_drop", 32'(tdc_rd_req), 0);
        check_record("nom", 1919, 32'h00ABCD, 0, 0);
        accept("nom");

        // PPS missing
        tos_mark = 1'b1;
        tick();
        ticks(Cps - 1);
        chk("miss.valid_pre", 32'(meas_valid), 0);
        chk("miss.stop", 32'(tdc_stop), 0);
        tos_mark = 1'b1;
        tick();
        check_record("miss", Cps - 1, 0, 1, 1);
        accept("miss");

        // Read timeout
        tos_mark = 1'b1;
        tick();
        pps_raw_rise = 1'b1;
        tick();
        slow_clock_rise_next = 1'b1;
        tick();
        ticks(Sw);
        chk("tmo.req_rise", 32'(tdc_rd_req), 1);
        ticks(Rt);
        chk("tmo.valid_pre", 32'(meas_valid), 0);
        chk("tmo.req_held", 32'(tdc_rd_req), 1);
        tick();
        check_record("tmo", 2, 0, 2, 0);
        chk("tmo.req_drop", 32'(tdc_rd_req), 0);
        accept("tmo");

        // Backpressure across two tos_marks
        quick_second(24'h123456);
        check_record("bp1", 2, 32'h123456, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tos_mark = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) begin
                check_record("bp1_hold", 2, 32'h123456, 0, 0);
                tick();
            end
        end
        accept("bp1");
        quick_second(24'h000042);
        check_record("bp2", 2, 32'h000042, 0, 1);
        accept("bp2");
        quick_second(24'h0F0F0F);
        check_record("bp3", 2, 32'h0F0F0F, 0, 0);
        accept("bp3");

        // PPS coincident with the tos_mark leaving idle is ignored
        tos_mark     = 1'b1;
        pps_raw_rise = 1'b1;
        tick();
        ticks(49);
        chk("sim.busy", 32'(busy), 1);
        chk("sim.valid", 32'(meas_valid), 0);
        slow_clock_rise_next = 1'b1;
        tick();
        chk("sim.stop", 32'(tdc_stop), 0);
        tos_mark = 1'b1;
        tick();
        check_record("sim", Cps - 1, 0, 1, 1);
        accept("sim");

        // Reset while tdc_stop is high, with a pending skip
        tos_mark = 1'b1;
        tick();
        pps_raw_rise = 1'b1;
        tick();
        slow_clock_rise_next = 1'b1;
        tick();
        ticks(10);
        tos_mark = 1'b1;
        tick();
        chk("rst.stop_high", 32'(tdc_stop), 1);
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid");
        rst = 1'b0;
        tick();
        check_all_zero("rst_rel");
        quick_second(24'h5A5A5A);
        check_record("rst_nom", 2, 32'h5A5A5A, 0, 0);
        accept("rst_nom");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
